// File: rtl/mips_pkg.sv
// Shared opcodes, FSM states and decode helpers for the 5-stage core.
// Imported by the interlock controller and its sub-modules.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  function automatic logic uses_rt(
    input logic [5:0] op
  );
    return (op == OP_RTYPE) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_BNE);
  endfunction

  function automatic logic is_mem(
    input logic [5:0] op
  );
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_hazard_ctrl_if.sv
// Pipeline-side bundle of the interlock controller: ID/EX/MEM/WB
// observations in, stall/bubble/hold, after-WB tracking and stats out.
interface mem_hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic [5:0]       id_op;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [5:0]       ex_op;
  logic [4:0]       ex_rd;
  logic [5:0]       mem_op;
  logic             mem_ready;
  logic [4:0]       memwb_rd;
  logic             memwb_regwrite;
  logic             stall_if;
  logic             bubble_ex;
  logic             hold_mem;
  logic [4:0]       after_rd;
  logic             after_valid;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_op, id_rs, id_rt,
    output ex_op, ex_rd,
    output mem_op, mem_ready,
    output memwb_rd, memwb_regwrite,
    input  stall_if, bubble_ex, hold_mem,
    input  after_rd, after_valid,
    input  mem_error, stall_cycles
  );

  modport slave (
    input  id_op, id_rs, id_rt,
    input  ex_op, ex_rd,
    input  mem_op, mem_ready,
    input  memwb_rd, memwb_regwrite,
    output stall_if, bubble_ex, hold_mem,
    output after_rd, after_valid,
    output mem_error, stall_cycles
  );

endinterface

// File: rtl/mem_hazard_ctrl_loaduse_detect.sv
// Combinational load-use detector: LW in EX whose destination feeds
// the instruction in ID (rs always, rt only for ops that read it).
module loaduse_detect
  import mips_pkg::*;
(
  input  logic [5:0] id_op,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [5:0] ex_op,
  input  logic [4:0] ex_rd,
  output logic       loaduse
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rd == id_rs);
  assign rt_hit = (ex_rd == id_rt) && uses_rt(id_op);

  assign loaduse = (ex_op == OP_LW) && (ex_rd != 5'd0) &&
                   (rs_hit || rt_hit);

endmodule

// File: rtl/mem_hazard_ctrl.sv
// Interlock controller: stall/bubble/hold generation, memory wait FSM
// with timeout trap, after-WB destination register and stall counter.
module mem_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  mem_hazard_ctrl_if.slave  bus
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

  state_t            state;
  state_t            state_n;
  logic [WC_W-1:0]   wait_cnt;
  logic [WC_W-1:0]   wait_cnt_n;
  logic [CNT_W-1:0]  stall_cnt;
  logic [4:0]        after_rd_q;
  logic              after_valid_q;

  logic mem_busy;
  logic loaduse;
  logic hold;
  logic stall;

  loaduse_detect u_lu (
    .id_op   (bus.id_op),
    .id_rs   (bus.id_rs),
    .id_rt   (bus.id_rt),
    .ex_op   (bus.ex_op),
    .ex_rd   (bus.ex_rd),
    .loaduse (loaduse)
  );

  assign mem_busy = is_mem(bus.mem_op) && !bus.mem_ready;

  // The FSM only times the wait; the freeze itself comes straight
  // from mem_busy so it costs no extra cycle.
  assign hold  = mem_busy || (state == ERR);
  assign stall = hold || loaduse;

  assign bus.hold_mem     = hold;
  assign bus.stall_if     = stall;
  assign bus.bubble_ex    = loaduse && !hold;
  assign bus.mem_error    = (state == ERR);
  assign bus.after_rd     = after_rd_q;
  assign bus.after_valid  = after_valid_q;
  assign bus.stall_cycles = stall_cnt;

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_busy) begin
          state_n    = WAIT;
          wait_cnt_n = WC_ONE;
        end
      end
      WAIT: begin
        if (bus.mem_ready) begin
          state_n    = RUN;
          wait_cnt_n = '0;
        end else if (wait_cnt == WC_MAX) begin
          state_n = ERR;
        end else begin
          wait_cnt_n = wait_cnt + WC_ONE;
        end
      end
      ERR: begin
        state_n = ERR;
      end
      default: begin
        state_n    = RUN;
        wait_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  // Frozen while held so a stalled SW keeps its forwarding source.
  always_ff @(posedge clock) begin
    if (reset) begin
      after_rd_q    <= 5'd0;
      after_valid_q <= 1'b0;
    end else if (!hold) begin
      after_rd_q    <= bus.memwb_rd;
      after_valid_q <= bus.memwb_regwrite &&
                       (bus.memwb_rd != 5'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_hazard_ctrl.sv
// Self-checking bench for mem_hazard_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_mem_hazard_ctrl;

  localparam int TO = 15;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2b;
  localparam logic [5:0] RT = 6'h00;
  localparam logic [5:0] BEQ = 6'h04;
  localparam logic [5:0] BNE = 6'h05;
  localparam logic [5:0] ADDI = 6'h08;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  mem_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  mem_hazard_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.id_op = ADDI;
    bus.id_rs = 5'd1;
    bus.id_rt = 5'd2;
    bus.ex_op = RT;
    bus.ex_rd = 5'd0;
    bus.mem_op = RT;
    bus.mem_ready = 1'b1;
    bus.memwb_rd = 5'd0;
    bus.memwb_regwrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [2:0] ctl();
    return {bus.stall_if, bus.bubble_ex, bus.hold_mem};
  endfunction

  task automatic test_reset();
    idle();
    do_reset();
    @(negedge clock);
    tests++;
    if ({ctl(), bus.mem_error} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctl: got %b want 0000",
               {ctl(), bus.mem_error});
    end
    tests++;
    if ({bus.after_rd, bus.after_valid, bus.stall_cycles} !== '0) begin
      fails++;
      $display("FAIL reset_regs: got rd=%0d v=%b cnt=%0d want 0",
               bus.after_rd, bus.after_valid, bus.stall_cycles);
    end
    cyc();
  endtask

  task automatic test_loaduse();
    idle();
    do_reset();
    bus.ex_op = LW; bus.ex_rd = 5'd5;
    bus.id_op = RT; bus.id_rs = 5'd5; bus.id_rt = 5'd3;
    @(negedge clock);
    tests++;
    if (ctl() !== 3'b110) begin
      fails++;
      $display("FAIL loaduse_stall: got %b want 110", ctl());
    end
    cyc();
    bus.mem_op = LW; bus.ex_op = RT; bus.ex_rd = 5'd0;
    @(negedge clock);
    tests++;
    if (ctl() !== 3'b000 || bus.stall_cycles !== 6'd1) begin
      fails++;
      $display("FAIL loaduse_release: got %b cnt=%0d want 000 cnt=1",
               ctl(), bus.stall_cycles);
    end
    cyc();
    idle();
  endtask

  task automatic test_rt_ignored();
    idle();
    bus.ex_op = LW; bus.ex_rd = 5'd5;
    bus.id_op = ADDI; bus.id_rs = 5'd2; bus.id_rt = 5'd5;
    @(negedge clock);
    tests++;
    if (ctl() !== 3'b000) begin
      fails++;
      $display("FAIL rt_ignored_addi: got %b want 000", ctl());
    end
    cyc();
    bus.ex_rd = 5'd0; bus.id_op = RT;
    bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    @(negedge clock);
    tests++;
    if (ctl() !== 3'b000) begin
      fails++;
      $display("FAIL rd_zero: got %b want 000", ctl());
    end
    cyc();
    bus.ex_rd = 5'd5; bus.id_op = SW; bus.id_rt = 5'd5;
    @(negedge clock);
    tests++;
    if (ctl() !== 3'b110) begin
      fails++;
      $display("FAIL rt_used_sw: got %b want 110", ctl());
    end
    cyc();
    idle();
  endtask

  task automatic test_mem_wait();
    idle();
    do_reset();
    bus.memwb_rd = 5'd7; bus.memwb_regwrite = 1'b1;
    cyc();
    bus.mem_op = SW; bus.mem_ready = 1'b0; bus.memwb_rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests++;
      if (ctl() !== 3'b101 || bus.after_rd !== 5'd7) begin
        fails++;
        $display("FAIL mem_wait_hold%0d: got %b rd=%0d want 101 rd=7",
                 i, ctl(), bus.after_rd);
      end
      cyc();
    end
    bus.mem_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (ctl() !== 3'b000 || bus.after_rd !== 5'd7) begin
      fails++;
      $display("FAIL mem_wait_ready: got %b rd=%0d want 000 rd=7",
               ctl(), bus.after_rd);
    end
    cyc();
    bus.mem_op = RT;
    @(negedge clock);
    tests++;
    if ({ctl(), bus.mem_error} !== 4'b0000 ||
        bus.after_rd !== 5'd12) begin
      fails++;
      $display("FAIL mem_wait_after: got %b err=%b rd=%0d want 000 0 12",
               ctl(), bus.mem_error, bus.after_rd);
    end
    cyc();
    idle();
  endtask

  task automatic test_timeout();
    idle();
    do_reset();
    bus.mem_op = LW; bus.mem_ready = 1'b0;
    for (int i = 0; i <= TO; i++) begin
      @(negedge clock);
      tests++;
      if (bus.hold_mem !== 1'b1 || bus.mem_error !== 1'b0) begin
        fails++;
        $display("FAIL timeout_busy%0d: got hold=%b err=%b want 1 0",
                 i, bus.hold_mem, bus.mem_error);
      end
      cyc();
    end
    @(negedge clock);
    tests++;
    if (bus.hold_mem !== 1'b1 || bus.mem_error !== 1'b1) begin
      fails++;
      $display("FAIL timeout_err: got hold=%b err=%b want 1 1",
               bus.hold_mem, bus.mem_error);
    end
    cyc();
    bus.mem_op = RT; bus.mem_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (ctl() !== 3'b101 || bus.mem_error !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got %b err=%b want 101 1",
               ctl(), bus.mem_error);
    end
    do_reset();
    @(negedge clock);
    tests++;
    if ({ctl(), bus.mem_error, bus.after_rd, bus.after_valid,
         bus.stall_cycles} !== '0) begin
      fails++;
      $display("FAIL err_reset: got ctl=%b err=%b cnt=%0d want 0",
               ctl(), bus.mem_error, bus.stall_cycles);
    end
    cyc();
  endtask

  task automatic test_after_wb();
    idle();
    bus.memwb_rd = 5'd9; bus.memwb_regwrite = 1'b1;
    cyc();
    @(negedge clock);
    tests++;
    if (bus.after_rd !== 5'd9 || bus.after_valid !== 1'b1) begin
      fails++;
      $display("FAIL after_9: got rd=%0d v=%b want 9 1",
               bus.after_rd, bus.after_valid);
    end
    bus.memwb_rd = 5'd0;
    cyc();
    @(negedge clock);
    tests++;
    if (bus.after_rd !== 5'd0 || bus.after_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_r0: got rd=%0d v=%b want 0 0",
               bus.after_rd, bus.after_valid);
    end
    bus.memwb_rd = 5'd9; bus.memwb_regwrite = 1'b0;
    cyc();
    @(negedge clock);
    tests++;
    if (bus.after_rd !== 5'd9 || bus.after_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_nowr: got rd=%0d v=%b want 9 0",
               bus.after_rd, bus.after_valid);
    end
    cyc();
    idle();
  endtask

  task automatic test_simultaneous();
    idle();
    do_reset();
    bus.ex_op = LW; bus.ex_rd = 5'd5;
    bus.id_op = RT; bus.id_rs = 5'd5;
    bus.mem_op = SW; bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests++;
      if (ctl() !== 3'b101) begin
        fails++;
        $display("FAIL simul_hold%0d: got %b want 101", i, ctl());
      end
      cyc();
    end
    bus.mem_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (ctl() !== 3'b110) begin
      fails++;
      $display("FAIL simul_bubble: got %b want 110", ctl());
    end
    cyc();
    bus.ex_op = RT; bus.ex_rd = 5'd0; bus.mem_op = LW;
    @(negedge clock);
    tests++;
    if (ctl() !== 3'b000 || bus.stall_cycles !== 6'd3) begin
      fails++;
      $display("FAIL simul_done: got %b cnt=%0d want 000 cnt=3",
               ctl(), bus.stall_cycles);
    end
    cyc();
    idle();
  endtask

  task automatic test_saturate();
    idle();
    do_reset();
    bus.ex_op = LW; bus.ex_rd = 5'd1;
    bus.id_op = ADDI; bus.id_rs = 5'd1;
    repeat (CMAX + 8) cyc();
    @(negedge clock);
    tests++;
    if (bus.stall_cycles !== CW'(CMAX)) begin
      fails++;
      $display("FAIL saturate: got %0d want %0d",
               bus.stall_cycles, CMAX);
    end
    cyc();
    idle();
  endtask

  function automatic bit m_uses_rt(logic [5:0] op);
    return op == RT || op == SW || op == BEQ || op == BNE;
  endfunction

  task automatic test_random();
    int m_run;
    bit m_err;
    int m_cnt;
    int m_ard;
    bit m_av;
    bit pend;
    int rem;
    bit acc, busy, lu, hold, stall;
    logic [5:0] ops [6];
    ops = '{RT, BEQ, BNE, LW, SW, ADDI};
    idle();
    do_reset();
    m_run = 0; m_err = 0; m_cnt = 0; m_ard = 0; m_av = 0;
    pend = 0; rem = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend && ($urandom % 2 == 0)) begin
        pend = 1;
        bus.mem_op = ($urandom % 2) ? LW : SW;
        rem = ($urandom % 150 == 0) ? int'($urandom_range(14, 20))
                                    : int'($urandom_range(0, 4));
      end else if (!pend) begin
        bus.mem_op = ops[$urandom % 3];
      end
      bus.mem_ready = pend ? (rem == 0) : 1'($urandom % 2);
      bus.id_op = ops[$urandom % 6];
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.ex_op = ($urandom % 2) ? LW : ops[$urandom % 6];
      bus.ex_rd = 5'($urandom_range(0, 3));
      bus.memwb_rd = 5'($urandom_range(0, 31));
      bus.memwb_regwrite = 1'($urandom % 2);
      reset = (m_err && ($urandom % 4 == 0)) || ($urandom % 500 == 0);

      acc = (bus.mem_op == LW) || (bus.mem_op == SW);
      busy = acc && !bus.mem_ready;
      lu = (bus.ex_op == LW) && (bus.ex_rd != 0) &&
           ((bus.ex_rd == bus.id_rs) ||
            ((bus.ex_rd == bus.id_rt) && m_uses_rt(bus.id_op)));
      hold = busy || m_err;
      stall = hold || lu;

      @(negedge clock);
      tests++;
      if ({ctl(), bus.mem_error} !== {stall, lu && !hold, hold, m_err}) begin
        fails++;
        $display("FAIL rand_ctl c%0d: got %b want %b", c,
                 {ctl(), bus.mem_error},
                 {stall, lu && !hold, hold, m_err});
      end
      tests++;
      if (bus.after_rd !== 5'(m_ard) || bus.after_valid !== m_av) begin
        fails++;
        $display("FAIL rand_after c%0d: got %0d/%b want %0d/%b", c,
                 bus.after_rd, bus.after_valid, m_ard, m_av);
      end
      tests++;
      if (bus.stall_cycles !== CW'(m_cnt)) begin
        fails++;
        $display("FAIL rand_cnt c%0d: got %0d want %0d", c,
                 bus.stall_cycles, m_cnt);
      end

      if (reset) begin
        m_run = 0; m_err = 0; m_cnt = 0; m_ard = 0; m_av = 0;
        pend = 0;
      end else begin
        if (stall && m_cnt < CMAX) m_cnt++;
        if (!hold) begin
          m_ard = int'(bus.memwb_rd);
          m_av = bus.memwb_regwrite && (bus.memwb_rd != 0);
        end
        if (!m_err) begin
          if (busy) begin
            m_run++;
            if (m_run == TO + 1) m_err = 1;
          end else begin
            m_run = 0;
          end
        end
        if (pend) begin
          if (rem == 0) pend = 0;
          else rem--;
        end
      end
      cyc();
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_loaduse();
    test_rt_ignored();
    test_mem_wait();
    test_timeout();
    test_after_wb();
    test_simultaneous();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
